move_executor: RTL and testbench

- Consumer end of the packed move-list interface driven by the setup-move generator.
- Latches a 4*NUM_MOVES-bit packed move vector on a one-cycle new_moves strobe, unpacks it into 4-bit move codes, and issues them one at a time to the motor driver over a valid/done handshake.
- Pulses seq_done when the list is exhausted; seq_done feeds the generator's send_setup_moves / counter-advance logic.

---
 rtl/move_executor.sv | 199 +++++++++++++++++++
 tb/tb_move_executor.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_executor.sv
// move_executor: consumer of the packed move list produced by the setup-move
// generator. It latches the list on a one-cycle strobe, walks it from slot
// NUM_MOVES-1 down to slot 0, and issues each legal move code to the motor
// driver over a valid/done handshake. It pulses seq_done when the list is
// exhausted.
//
// Optional feature macro: MOVE_TIMEOUT_EN. When defined, a watchdog limits
// how long WAIT may hold a move. If move_done does not arrive within
// TIMEOUT_CYCLES, the rest of the list is abandoned. When undefined, WAIT
// holds indefinitely and the timeout output is tied low.
module move_executor #(
  parameter int NUM_MOVES      = 50,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [4*NUM_MOVES-1:0] moves,
  input  logic                   new_moves,
  output logic [3:0]             move_code,
  output logic                   move_valid,
  input  logic                   move_done,
  output logic                   busy,
  output logic                   seq_done,
  output logic                   bad_code,
  output logic                   overrun,
  output logic                   timeout
);

  localparam int IDX_W = (NUM_MOVES > 1) ? $clog2(NUM_MOVES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [4*NUM_MOVES-1:0] mbuf_q, mbuf_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [3:0]             code_q, code_d;
  logic                   valid_q, valid_d;
  logic                   busy_q;
  logic                   seq_done_q, seq_done_d;
  logic                   bad_q, bad_d;
  logic                   overrun_q, overrun_d;

`ifdef MOVE_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0]            cnt_q, cnt_d;
  logic                   timeout_q, timeout_d;
`endif

  // Unpack the latched vector into addressable 4-bit slots.
  logic [3:0] slot [NUM_MOVES];
  for (genvar gi = 0; gi < NUM_MOVES; gi++) begin : g_slot
    assign slot[gi] = mbuf_q[4*gi +: 4];
  end

  logic [3:0] cur_code;
  logic       code_is_move;
  logic       code_is_bad;

  assign cur_code     = slot[idx_q];
  // 2..13 are real face turns; 0 is padding; 1, 14 and 15 are illegal.
  assign code_is_move = (cur_code >= 4'd2) && (cur_code <= 4'd13);
  assign code_is_bad  = (cur_code == 4'd1) || (cur_code >= 4'd14);

  // Next-state and next-output logic for the scan/issue sequencer.
  always_comb begin
    state_d    = state_q;
    mbuf_d     = mbuf_q;
    idx_d      = idx_q;
    code_d     = code_q;
    valid_d    = valid_q;
    seq_done_d = 1'b0;
    bad_d      = bad_q;
    overrun_d  = overrun_q;
`ifdef MOVE_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
`endif

    // A strobe is only accepted from a quiet IDLE. The cycle that shows the
    // seq_done pulse still counts as part of the previous list.
    if (new_moves && ((state_q != S_IDLE) || seq_done_q)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (new_moves && !seq_done_q) begin
          mbuf_d  = moves;
          idx_d   = LAST_IDX;
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        if (code_is_move) begin
          code_d  = cur_code;
          valid_d = 1'b1;
          state_d = S_WAIT;
`ifdef MOVE_TIMEOUT_EN
          cnt_d   = 32'd0;
`endif
        end else begin
          // Padding and illegal codes are both skipped; illegal ones are flagged.
          if (code_is_bad) begin
            bad_d = 1'b1;
          end
          if (idx_q == '0) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end

      S_WAIT: begin
        if (move_done) begin
          // A done on the expiry cycle takes priority over the timeout.
          valid_d = 1'b0;
          if (idx_q == '0) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = S_SCAN;
          end
        end
`ifdef MOVE_TIMEOUT_EN
        else if (cnt_q >= TIMEOUT_LAST) begin
          timeout_d = 1'b1;
          valid_d   = 1'b0;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
`endif
      end

      S_DONE: begin
        seq_done_d = 1'b1;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any sequence in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mbuf_q     <= '0;
      idx_q      <= '0;
      code_q     <= 4'd0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      seq_done_q <= 1'b0;
      bad_q      <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
      cnt_q      <= 32'd0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mbuf_q     <= mbuf_d;
      idx_q      <= idx_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      busy_q     <= (state_d != S_IDLE);
      seq_done_q <= seq_done_d;
      bad_q      <= bad_d;
      overrun_q  <= overrun_d;
`ifdef MOVE_TIMEOUT_EN
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign move_code  = code_q;
  assign move_valid = valid_q;
  assign busy       = busy_q;
  assign seq_done   = seq_done_q;
  assign bad_code   = bad_q;
  assign overrun    = overrun_q;
`ifdef MOVE_TIMEOUT_EN
  assign timeout    = timeout_q;
`else
  assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_move_executor.sv
// Testbench for move_executor. Random and directed move lists are checked
// against a timing model derived from the slot-walk rules.
module tb_move_executor;
  localparam int NM = 16;
  localparam int TO = 20;
`ifdef MOVE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4*NM-1:0] moves = '0;
  logic          new_moves = 1'b0;
  logic          move_done = 1'b0;
  logic [3:0]    move_code;
  logic          move_valid, busy, seq_done, bad_code, overrun, timeout;

  move_executor #(.NUM_MOVES(NM), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clk), .reset(rst), .moves(moves), .new_moves(new_moves),
    .move_code(move_code), .move_valid(move_valid), .move_done(move_done),
    .busy(busy), .seq_done(seq_done), .bad_code(bad_code),
    .overrun(overrun), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_bad, exp_over, exp_to;
  int dly [NM];

  // Model results: offsets are in cycles relative to the strobe cycle.
  int e_code[$], e_rise[$], e_fall[$];
  int e_sd;
  bit m_bad, m_to;

  // Expected behaviour: walk slots from top to bottom. A skipped slot costs
  // one cycle. A move appears one cycle after its scan slot and is
  // acknowledged after its delay. seq_done follows the last slot by one cycle.
  task automatic model(input logic [4*NM-1:0] v);
    int cur, mi, c, rise;
    logic [4*NM-1:0] t;
    e_code.delete(); e_rise.delete(); e_fall.delete();
    m_bad = 1'b0; m_to = 1'b0;
    cur = 1; mi = 0;
    for (int k = NM - 1; k >= 0; k--) begin
      t = v >> (4 * k);
      c = int'(t[3:0]);
      if (c >= 2 && c <= 13) begin
        rise = cur + 1;
        e_code.push_back(c);
        e_rise.push_back(rise);
        if (TO_EN && dly[mi] >= TO) begin
          m_to = 1'b1;
          e_fall.push_back(rise + TO);
          cur = rise + TO;
          break;
        end
        e_fall.push_back(rise + dly[mi] + 1);
        cur = rise + dly[mi] + 1;
        mi++;
      end else begin
        if (c != 0) m_bad = 1'b1;
        cur++;
      end
    end
    e_sd = cur + 1;
  endtask

  task automatic set_delays(input int lo, input int hi);
    for (int i = 0; i < NM; i++) dly[i] = int'($urandom_range(hi, lo));
  endtask

  function automatic logic [4*NM-1:0] rand_list(input bit allow_bad);
    logic [4*NM-1:0] v;
    int top, r;
    v = '0;
    top = int'($urandom_range(NM - 1, 0));
    for (int k = 0; k <= top; k++) begin
      r = int'($urandom_range(99, 0));
      if (k == top || r < 65) v[4*k +: 4] = 4'($urandom_range(13, 2));
      else if (allow_bad && r >= 94) v[4*k +: 4] = 4'd15;
      else if (allow_bad && r >= 90) v[4*k +: 4] = (r >= 92) ? 4'd14 : 4'd1;
    end
    return v;
  endfunction

  // Drive one list and emulate the motor driver.
  // mode 1 re-strobes during the first WAIT.
  // mode 2 re-strobes on the seq_done cycle.
  task automatic run_list(input logic [4*NM-1:0] v, input int mode,
                          input int trail, input string name);
    int c0, dcnt, budget, di, off;
    bit prev_v, seen_sd, code_bad, busy_gap;
    logic [3:0] held;
    int o_code[$], o_rise[$], o_fall[$], o_sd[$];
    model(v);
    exp_bad = exp_bad | m_bad;
    exp_to  = exp_to | m_to;
    budget  = e_sd + 30;
    @(negedge clk);
    moves = v; new_moves = 1'b1; move_done = 1'b0;
    c0 = cyc; prev_v = 1'b0; seen_sd = 1'b0; code_bad = 1'b0; busy_gap = 1'b0;
    dcnt = 0; held = 4'd0;
    for (int i = 0; i < budget && !seen_sd; i++) begin
      @(negedge clk);
      new_moves = 1'b0; move_done = 1'b0;
      off = cyc - c0;
      if (off < e_sd && busy !== 1'b1) busy_gap = 1'b1;
      if (move_valid === 1'b1 && !prev_v) begin
        o_code.push_back(int'(move_code));
        o_rise.push_back(off);
        held = move_code;
        di = o_code.size() - 1;
        dcnt = (di < NM) ? dly[di] : 0;
        if (mode == 1 && o_code.size() == 1) begin
          new_moves = 1'b1; moves = ~v; exp_over = 1'b1;
        end
      end else if (move_valid === 1'b1 && move_code !== held) begin
        code_bad = 1'b1;
      end
      if (move_valid !== 1'b1 && prev_v) o_fall.push_back(off);
      if (move_valid === 1'b1) begin
        if (dcnt == 0) move_done = 1'b1;
        dcnt--;
      end
      if (seq_done === 1'b1) begin
        o_sd.push_back(off);
        seen_sd = 1'b1;
        if (mode == 2) begin
          new_moves = 1'b1; moves = ~v; exp_over = 1'b1;
        end
      end
      prev_v = (move_valid === 1'b1);
    end
    for (int i = 0; i < trail; i++) begin
      @(negedge clk);
      new_moves = 1'b0; move_done = 1'b0;
      if (seq_done === 1'b1) o_sd.push_back(cyc - c0);
      n_checks++;
      if (busy !== 1'b0 || move_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s idle_after_done: busy=%b valid=%b, required 0 0", name, busy, move_valid);
      end
    end
    $display("list %s: %0d moves issued, seq_done at +%0d (model +%0d)", name,
             o_code.size(), seen_sd ? o_sd[0] : -1, e_sd);
    n_checks++;
    if (!seen_sd) begin
      n_fail++;
      $display("FAIL %s seq_done_seen: none within %0d cycles, required one", name, budget);
    end
    n_checks++;
    if (o_code.size() != e_code.size()) begin
      n_fail++;
      $display("FAIL %s move_count: got %0d, required %0d", name, o_code.size(), e_code.size());
    end
    for (int i = 0; i < e_code.size() && i < o_code.size(); i++) begin
      n_checks++;
      if (o_code[i] != e_code[i] || o_rise[i] != e_rise[i]) begin
        n_fail++;
        $display("FAIL %s move[%0d]: code %0d at +%0d, required code %0d at +%0d",
                 name, i, o_code[i], o_rise[i], e_code[i], e_rise[i]);
      end
      if (i < o_fall.size()) begin
        n_checks++;
        if (o_fall[i] != e_fall[i]) begin
          n_fail++;
          $display("FAIL %s valid_drop[%0d]: at +%0d, required +%0d", name, i, o_fall[i], e_fall[i]);
        end
      end
    end
    if (seen_sd) begin
      n_checks++;
      if (o_sd[0] != e_sd || o_sd.size() != 1) begin
        n_fail++;
        $display("FAIL %s seq_done: first at +%0d count %0d, required +%0d count 1",
                 name, o_sd[0], o_sd.size(), e_sd);
      end
    end
    n_checks++;
    if (code_bad || busy_gap) begin
      n_fail++;
      $display("FAIL %s hold: code_changed=%b busy_dropped=%b, required 0 0", name, code_bad, busy_gap);
    end
    n_checks++;
    if (bad_code !== exp_bad || overrun !== exp_over || timeout !== exp_to) begin
      n_fail++;
      $display("FAIL %s flags: bad=%b over=%b to=%b, required %b %b %b", name,
               bad_code, overrun, timeout, exp_bad, exp_over, exp_to);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({move_code, move_valid, busy, seq_done, bad_code, overrun, timeout} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_state: code=%0d v=%b busy=%b sd=%b bad=%b ov=%b to=%b, required all 0",
               move_code, move_valid, busy, seq_done, bad_code, overrun, timeout);
    end
    rst = 1'b0;
    exp_bad = 1'b0; exp_over = 1'b0; exp_to = 1'b0;
    $display("reset: outputs sampled after reset");
  endtask

  task automatic test_basic();
    logic [4*NM-1:0] v;
    v = '0;
    v[15:0] = 16'h2945;
    for (int i = 0; i < NM; i++) dly[i] = 3;
    run_list(v, 0, 2, "basic");
  endtask

  task automatic test_all_zero();
    set_delays(0, 0);
    run_list('0, 0, 2, "all_zero");
  endtask

  task automatic test_back_to_back();
    set_delays(0, 3);
    run_list(rand_list(1'b0), 0, 0, "b2b_first");
    set_delays(0, 3);
    run_list(rand_list(1'b0), 0, 2, "b2b_second");
  endtask

  task automatic test_bad_code();
    logic [4*NM-1:0] v;
    v = '0;
    v[11:0] = 12'h6F7;
    set_delays(0, 4);
    run_list(v, 0, 2, "bad_code");
    set_delays(0, 2);
    run_list(rand_list(1'b0), 0, 2, "bad_sticky");
  endtask

  task automatic test_reset_mid();
    logic [4*NM-1:0] v;
    bit found;
    v = '0;
    v[4*(NM-1) +: 4] = 4'd10;
    v[3:0] = 4'd3;
    @(negedge clk);
    moves = v; new_moves = 1'b1; found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      new_moves = 1'b0;
      if (move_valid === 1'b1 && move_code === 4'd10) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL reset_mid_issue: code 10 never valid, required valid");
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({move_code, move_valid, busy, seq_done, bad_code, overrun, timeout} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: code=%0d v=%b busy=%b sd=%b bad=%b ov=%b to=%b, required all 0",
               move_code, move_valid, busy, seq_done, bad_code, overrun, timeout);
    end
    $display("reset_mid: reset applied while code 10 valid");
    exp_bad = 1'b0; exp_over = 1'b0; exp_to = 1'b0;
    v = '0;
    v[4*(NM/2) +: 4] = 4'd12;
    v[4 +: 4] = 4'd4;
    set_delays(0, 2);
    run_list(v, 0, 2, "after_reset");
  endtask

  task automatic test_overrun();
    set_delays(1, 4);
    run_list(rand_list(1'b0), 1, 2, "overrun_wait");
    set_delays(0, 2);
    run_list(rand_list(1'b0), 2, 3, "overrun_done");
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      set_delays(0, 4);
      run_list(rand_list(1'b1), 0, 1, $sformatf("random%0d", n));
    end
  endtask

`ifdef MOVE_TIMEOUT_EN
  task automatic test_timeout();
    logic [4*NM-1:0] v;
    v = '0;
    v[4*5 +: 4] = 4'd6;
    v[4*2 +: 4] = 4'd8;
    for (int i = 0; i < NM; i++) dly[i] = TO - 1;
    run_list(v, 0, 2, "done_at_limit");
    for (int i = 0; i < NM; i++) dly[i] = 1000;
    run_list(v, 0, 2, "timeout");
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_all_zero();
    test_back_to_back();
    test_bad_code();
    test_reset_mid();
    test_overrun();
    test_random();
`ifdef MOVE_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
